wrr_grant_arbiter: RTL and testbench
====================================

# wrr_grant_arbiter

Weighted round-robin grant arbiter with held grants, for DMA channel scheduling. It succeeds the single-cycle round-robin arbiter. Once a channel wins, its grant is held until the channel has received a programmable number of beats (its weight) or drops its request. The grant is then released and the next winner loads in the same cycle, with no bubble. It sits between the per-channel request logic and the shared bus master, and it also supports a fixed-priority mode.

## Interface
- `REQ_NUM`, 4: number of requesting channels, ≥2.
- `WEIGHT_W`, 4: width of each per-channel weight field.
- `ID_W`, $clog2(REQ_NUM): width of `gnt_id`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqs`  in  REQ_NUM  per-channel request, level.
- `weights`  in  REQ_NUM*WEIGHT_W  beats per grant; channel i at bits [i*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1.
- `mode`  in  1  0 = weighted round-robin, 1 = fixed priority (lowest index wins).
- `gnt_ack`  in  1  consumer accepted one beat of the current owner.
- `grans`  out  REQ_NUM  one-hot grant, registered.
- `gnt_valid`  out  1  high while any grant is held; equals `|grans`.
- `gnt_id`  out  ID_W  binary index of the owner; 0 when idle.
- `credit_left`  out  WEIGHT_W  remaining beats of the current grant.

## Operation
- **States:**
  - IDLE: no grant held.
  - BUSY: `grans` is held stable.
- **Winner pick (combinational):**
  - Form `double = {reqs, reqs}`, then `g = double & ~(double - base)`.
  - `winner = g[2N-1:N] | g[N-1:0]`, where `base` is one-hot.
  - In mode 1, `base` is forced to 1.
- **IDLE:**
  - If `|reqs`: load `grans = winner`, `gnt_id = index(winner)`, `credit_left = max(weight[winner], 1)`, then go to BUSY.
  - Otherwise stay in IDLE with all outputs 0.
- **BUSY, release events:**
  - Beat-release: `gnt_ack` while `credit_left == 1`.
  - Abandon: the owner's `reqs` bit is low, with or without `gnt_ack`.
- **BUSY, no release:** `gnt_ack` decrements `credit_left` by 1; the grant is unchanged.
- **BUSY, on release:**
  - `base` becomes the owner rotated left by one (circular: MSB wraps to bit 0).
  - In the same cycle the winner is recomputed from the current `reqs` using the new `base`.
  - If any request exists, the next winner loads directly and the state stays BUSY.
  - Otherwise `grans`, `gnt_id` and `credit_left` clear to 0 and the state goes to IDLE.
  - An owner that is still requesting after weight exhaustion has the lowest priority. It is re-granted only if it is the sole requester, and it then receives a fresh credit load.
- **Ignored inputs:**
  - `gnt_ack` in IDLE has no effect.
  - `weights` and `mode` are sampled only at grant load; changes mid-grant take effect at the next load.
- **Arithmetic:** `credit_left` never underflows. The load value is 1..2^WEIGHT_W-1.

## Timing
- **Reset values:** `grans` = 0, `gnt_valid` = 0, `gnt_id` = 0, `credit_left` = 0, `base` = 1, state IDLE. The reset is asynchronous: it clears a grant mid-transfer immediately, and arbitration restarts from ch0.
- **Latency:**
  - `reqs` to `grans`: 1 cycle (the edge after the request is seen in IDLE).
  - Release edge to next owner's `grans`: 0 extra cycles (back-to-back).
- **Handshake:**
  - One `gnt_ack` equals one beat, counted at the edge where it is sampled high with `gnt_valid` = 1.
  - The consumer must not assert `gnt_ack` for a cycle in which `gnt_valid` = 0; such an ack is ignored.
- **Simultaneous owner-drop and ack:** treated as a single release. The rotation rule is identical for both release causes.

## Structure
- **Package `dma_arb_pkg`:**
  - State enum `ARB_IDLE` / `ARB_BUSY`.
  - Function `onehot2idx`.
  - Function `rotl1` (circular one-hot rotate).
- **Sub-module `rr_pick`:** combinational double-request subtract picker. Inputs `reqs` and `base`; output `winner`. Parametrised by `REQ_NUM`; reusable by other arbiters.
- **Top level:** state register, `base` register, credit counter, output registers.

## Test plan
- **Equal weights, full load.** REQ_NUM=4, weights all 1, `reqs`=1111 from reset, `gnt_ack` every cycle → `grans` 0001, 0010, 0100, 1000, 0001…, one per cycle, no idle cycle between owners.
- **Weighted hold.** Weights {ch3..ch0} = {1,1,1,3}, `reqs`=0011, `gnt_ack` continuous → ch0 held for 3 acks (`credit_left` 3, 2, 1), then ch1 for 1, then ch0 for 3 again.
- **Abandon.** ch1 granted with `credit_left`=4; clear `reqs[1]` without ack while `reqs`=0100 → next edge `grans`=0100 and `credit_left` = weight[2]. With `reqs`=0000 instead → `grans`=0 and state IDLE.
- **Fixed priority.** `mode`=1, `reqs`=1010, weights 1, `gnt_ack` continuous → `grans` = 0010 every grant; ch3 is never granted while `reqs[1]` is high.
- **Corner cases.**
  - Weight 0 on ch2: ch2 releases after exactly 1 ack.
  - `gnt_ack` pulsed in IDLE: outputs stay 0.
  - `rst` pulsed mid-grant (ch3, `credit_left`=2): outputs go to 0 immediately; the next grant with `reqs`=1111 is ch0.
- **Sole requester re-grant.** `reqs`=0100, weight 2, continuous ack → ch2 re-granted back-to-back with `credit_left` reloaded to 2 each time.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// ---------------------------------------------------------------------------
// dma_arb_pkg
//
// Shared types and helpers for the DMA channel arbiters.
//   arb_state_t : arbiter state (ARB_IDLE = no grant held, ARB_BUSY = grant held)
//   MAX_REQ     : widest request vector the helper functions accept
//   onehot2idx  : binary index of a one-hot vector (0 for an all-zero vector)
//   rotl1       : circular rotate-left-by-one of a one-hot vector of a given width
// ---------------------------------------------------------------------------
package dma_arb_pkg;

  localparam int MAX_REQ = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Returns the bit position of the set bit. OR-ing the positions keeps the
  // logic a simple encoder rather than a priority chain, which is safe
  // because the input is guaranteed one-hot (or zero).
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Rotates the lowest 'width' bits left by one; bit width-1 wraps to bit 0.
  // Bits at or above 'width' come back as zero.
  function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] onehot,
                                               input int width);
    logic [MAX_REQ-1:0] rot;
    rot = '0;
    for (int i = 0; i < MAX_REQ - 1; i++) begin
      if (i + 1 < width) begin
        rot[i+1] = onehot[i];
      end
    end
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i == width - 1) begin
        rot[0] = onehot[i];
      end
    end
    return rot;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Returns the first requester found when
// scanning upward (circularly) from the one-hot 'base' position.
//   reqs   in  REQ_NUM  request vector
//   base   in  REQ_NUM  one-hot starting position of the scan
//   winner out REQ_NUM  one-hot winner, zero when no request is present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int REQ_NUM = 4
) (
  input  logic [REQ_NUM-1:0] reqs,
  input  logic [REQ_NUM-1:0] base,
  output logic [REQ_NUM-1:0] winner
);

  logic [2*REQ_NUM-1:0] double_req;
  logic [2*REQ_NUM-1:0] base_ext;
  logic [2*REQ_NUM-1:0] grant_dbl;

  // Duplicating the request vector lets a plain subtract find the first set
  // bit at or above 'base' without wrap logic: the borrow ripples up from
  // base until it hits a request, and masking keeps only that bit. A request
  // below base is found in the upper copy, so folding both halves together
  // gives the circular result.
  always_comb begin
    double_req = {reqs, reqs};
    base_ext   = {{REQ_NUM{1'b0}}, base};
    grant_dbl  = double_req & ~(double_req - base_ext);
    winner     = grant_dbl[2*REQ_NUM-1:REQ_NUM] | grant_dbl[REQ_NUM-1:0];
  end

endmodule

// File: rtl/wrr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_grant_arbiter
//
// Weighted round-robin arbiter with held grants for DMA channel scheduling.
// A winning channel keeps its grant until it has been acknowledged 'weight'
// times or drops its request; the next winner then loads on the same edge.
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   reqs        in   per-channel level requests
//   weights     in   per-channel beats per grant, channel i at [i*WEIGHT_W +: WEIGHT_W],
//                    zero behaves as one
//   mode        in   0 = weighted round-robin, 1 = fixed priority (lowest index wins)
//   gnt_ack     in   one beat of the current owner accepted
//   grans       out  registered one-hot grant
//   gnt_valid   out  any grant held
//   gnt_id      out  binary index of the owner, 0 when idle
//   credit_left out  beats remaining in the current grant
// ---------------------------------------------------------------------------
module wrr_grant_arbiter
  import dma_arb_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           reqs,
  input  logic [REQ_NUM*WEIGHT_W-1:0]  weights,
  input  logic                         mode,
  input  logic                         gnt_ack,
  output logic [REQ_NUM-1:0]           grans,
  output logic                         gnt_valid,
  output logic [ID_W-1:0]              gnt_id,
  output logic [WEIGHT_W-1:0]          credit_left
);

  arb_state_t            state_q, state_d;
  logic [REQ_NUM-1:0]    base_q, base_d;
  logic [REQ_NUM-1:0]    grans_q, grans_d;
  logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;

  logic [REQ_NUM-1:0]    rot_base;
  logic [REQ_NUM-1:0]    pick_base;
  logic [REQ_NUM-1:0]    winner;
  logic [WEIGHT_W-1:0]   winner_weight;
  logic [WEIGHT_W-1:0]   load_credit;
  logic [ID_W-1:0]       winner_id;
  logic                  owner_req;
  logic                  beat_release;
  logic                  release_evt;

  // The base for the pick depends on why we are arbitrating. In IDLE the
  // stored base is used. In BUSY the pick only matters on a release, and
  // then it must already use the rotated base so the next owner can load on
  // the same edge. Fixed-priority mode always scans from channel 0.
  always_comb begin
    rot_base = REQ_NUM'(rotl1(MAX_REQ'(grans_q), REQ_NUM));
    if (mode) begin
      pick_base = REQ_NUM'(1);
    end else if (state_q == ARB_BUSY) begin
      pick_base = rot_base;
    end else begin
      pick_base = base_q;
    end
  end

  rr_pick #(
    .REQ_NUM (REQ_NUM)
  ) u_pick (
    .reqs   (reqs),
    .base   (pick_base),
    .winner (winner)
  );

  // The winner is one-hot, so OR-ing the masked weight fields selects its
  // weight. A zero weight loads as one so every grant lasts at least a beat.
  always_comb begin
    winner_weight = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (winner[i]) begin
        winner_weight = winner_weight | weights[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    load_credit = (winner_weight == '0) ? WEIGHT_W'(1) : winner_weight;
    winner_id   = ID_W'(onehot2idx(MAX_REQ'(winner)));
  end

  // A held grant ends either on its last acknowledged beat or as soon as the
  // owner stops requesting; both causes rotate the base the same way.
  always_comb begin
    owner_req    = |(reqs & grans_q);
    beat_release = gnt_ack && (credit_q == WEIGHT_W'(1));
    release_evt  = (state_q == ARB_BUSY) && (!owner_req || beat_release);
  end

  // Next-state logic. A release with other requests pending goes straight to
  // the next owner; only an empty request vector drops back to IDLE. Acks
  // outside a grant are ignored, and the credit only decrements while it is
  // above one, so it cannot wrap.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    grans_d  = grans_q;
    gnt_id_d = gnt_id_q;
    credit_d = credit_q;

    case (state_q)
      ARB_IDLE: begin
        if (|reqs) begin
          grans_d  = winner;
          gnt_id_d = winner_id;
          credit_d = load_credit;
          state_d  = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        if (release_evt) begin
          base_d = rot_base;
          if (|reqs) begin
            grans_d  = winner;
            gnt_id_d = winner_id;
            credit_d = load_credit;
            state_d  = ARB_BUSY;
          end else begin
            grans_d  = '0;
            gnt_id_d = '0;
            credit_d = '0;
            state_d  = ARB_IDLE;
          end
        end else if (gnt_ack) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end

      default: begin
        state_d  = ARB_IDLE;
        base_d   = REQ_NUM'(1);
        grans_d  = '0;
        gnt_id_d = '0;
        credit_d = '0;
      end
    endcase
  end

  // State and output registers. Reset drops any grant at once and restarts
  // arbitration from channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      base_q   <= REQ_NUM'(1);
      grans_q  <= '0;
      gnt_id_q <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      grans_q  <= grans_d;
      gnt_id_q <= gnt_id_d;
      credit_q <= credit_d;
    end
  end

  assign grans       = grans_q;
  assign gnt_valid   = |grans_q;
  assign gnt_id      = gnt_id_q;
  assign credit_left = credit_q;

endmodule

// File: tb/tb_wrr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_grant_arbiter
//
// Directed bench for wrr_grant_arbiter with hand-computed expected values.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_wrr_grant_arbiter;

  localparam int REQ_NUM  = 4;
  localparam int WEIGHT_W = 4;
  localparam int ID_W     = 2;

  logic                        clk;
  logic                        rst;
  logic [REQ_NUM-1:0]          reqs;
  logic [REQ_NUM*WEIGHT_W-1:0] weights;
  logic                        mode;
  logic                        gnt_ack;
  logic [REQ_NUM-1:0]          grans;
  logic                        gnt_valid;
  logic [ID_W-1:0]             gnt_id;
  logic [WEIGHT_W-1:0]         credit_left;

  int test_count;
  int fail_count;

  wrr_grant_arbiter #(
    .REQ_NUM  (REQ_NUM),
    .WEIGHT_W (WEIGHT_W),
    .ID_W     (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reqs        (reqs),
    .weights     (weights),
    .mode        (mode),
    .gnt_ack     (gnt_ack),
    .grans       (grans),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .credit_left (credit_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one set of inputs, lets one rising edge pass and settles just after it.
  task automatic applyStimulus(input logic [REQ_NUM-1:0] r, input logic ack);
    reqs    = r;
    gnt_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reqs    = '0;
    gnt_ack = 1'b0;
    mode    = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkGrant(input string tag, input logic [REQ_NUM-1:0] exp_gnt,
                            input logic [ID_W-1:0] exp_id,
                            input logic [WEIGHT_W-1:0] exp_credit);
    checkOutput({tag, ".grans"}, 32'(grans), 32'(exp_gnt));
    checkOutput({tag, ".valid"}, 32'(gnt_valid), 32'(|exp_gnt));
    checkOutput({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    checkOutput({tag, ".credit"}, 32'(credit_left), 32'(exp_credit));
  endtask

  logic [3:0] exp_rr [5];
  logic [1:0] exp_rr_id [5];
  logic [3:0] exp_wh [5];
  logic [3:0] exp_wh_cr [5];
  logic [3:0] exp_sole_cr [5];

  initial begin
    test_count = 0;
    fail_count = 0;
    weights    = 16'h1111;
    exp_rr      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_wh      = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    exp_wh_cr   = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd3};
    exp_sole_cr = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2};

    // Reset state.
    doReset();
    checkGrant("reset", 4'b0000, 2'd0, 4'd0);

    // Equal weights, full load: one owner per cycle, rotating.
    weights = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b1);
      checkGrant($sformatf("rr%0d", i), exp_rr[i], exp_rr_id[i], 4'd1);
    end

    // Weighted hold: ch0 weight 3, ch1 weight 1.
    doReset();
    weights = 16'h1113;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, 1'b1);
      checkOutput($sformatf("wh%0d.grans", i), 32'(grans), 32'(exp_wh[i]));
      checkOutput($sformatf("wh%0d.credit", i), 32'(credit_left), 32'(exp_wh_cr[i]));
    end

    // Abandon to another requester: ch1 (weight 4) drops, ch2 (weight 5) takes over.
    doReset();
    weights = 16'h1541;
    applyStimulus(4'b0010, 1'b0);
    checkGrant("ab_load", 4'b0010, 2'd1, 4'd4);
    applyStimulus(4'b0100, 1'b0);
    checkGrant("ab_next", 4'b0100, 2'd2, 4'd5);
    applyStimulus(4'b0000, 1'b0);
    checkGrant("ab_idle2", 4'b0000, 2'd0, 4'd0);

    // Abandon with no other requester goes idle.
    doReset();
    applyStimulus(4'b0010, 1'b0);
    checkGrant("ab2_load", 4'b0010, 2'd1, 4'd4);
    applyStimulus(4'b0000, 1'b0);
    checkGrant("ab2_idle", 4'b0000, 2'd0, 4'd0);

    // Fixed priority: ch1 always beats ch3.
    doReset();
    weights = 16'h1111;
    mode    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1010, 1'b1);
      checkOutput($sformatf("fp%0d.grans", i), 32'(grans), 32'(4'b0010));
    end

    // Weight 0 on ch2 behaves as 1: one ack then ch3 follows.
    doReset();
    weights = 16'h1011;
    applyStimulus(4'b1100, 1'b1);
    checkGrant("w0_load", 4'b0100, 2'd2, 4'd1);
    applyStimulus(4'b1100, 1'b1);
    checkGrant("w0_next", 4'b1000, 2'd3, 4'd1);

    // Ack while idle has no effect.
    doReset();
    applyStimulus(4'b0000, 1'b1);
    checkGrant("idle_ack0", 4'b0000, 2'd0, 4'd0);
    applyStimulus(4'b0000, 1'b1);
    checkGrant("idle_ack1", 4'b0000, 2'd0, 4'd0);

    // Asynchronous reset in the middle of a ch3 grant.
    doReset();
    weights = 16'h4111;
    applyStimulus(4'b1000, 1'b1);
    checkGrant("mr_load", 4'b1000, 2'd3, 4'd4);
    applyStimulus(4'b1000, 1'b1);
    applyStimulus(4'b1000, 1'b1);
    checkGrant("mr_mid", 4'b1000, 2'd3, 4'd2);
    #2;
    rst = 1'b1;
    #1;
    checkGrant("mr_async", 4'b0000, 2'd0, 4'd0);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    checkGrant("mr_restart", 4'b0001, 2'd0, 4'd1);

    // Sole requester re-granted back-to-back with a fresh credit.
    doReset();
    weights = 16'h1211;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, 1'b1);
      checkGrant($sformatf("sole%0d", i), 4'b0100, 2'd2, exp_sole_cr[i]);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
